// File: rtl/rf_writeback_scheduler_if.sv
// Writeback source bundle: sources A (ALU) and B (load) toward the scheduler.
// No latency of its own; it only carries the signals.
// A source holding valid=1 with ready=0 keeps rd/data stable until granted.
interface rf_writeback_scheduler_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_rd;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_rd;
  logic [DW-1:0] b_data;

  // Execute/memory side: presents writebacks and receives grants.
  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready
  );

  // Scheduler side: receives writebacks and issues grants.
  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/rf_writeback_scheduler.sv
// Round-robin scheduler of two writeback sources onto the RF write port, with busy scoreboard and RAW/WAW stalls.
// Grant is combinational; rf_we/rf_wda/rf_wd are registered one cycle after the handshake.
// The source that loses arbitration sees ready=0 and holds its request; nothing is ever dropped.
module rf_writeback_scheduler #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic                   CLK,
  input  logic                   RESET,
  rf_writeback_scheduler_if.slave wb,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_rd,
  output logic                   issue_stall,
  input  logic [AW-1:0]          rs1,
  input  logic [AW-1:0]          rs2,
  output logic                   raw_stall,
  output logic                   rf_we,
  output logic [AW-1:0]          rf_wda,
  output logic [DW-1:0]          rf_wd
);

  localparam int NREG = 2 ** AW;

  // Which source wins when both are valid.
  typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

  pri_t            pri_q;
  pri_t            pri_d;
  logic            grant_a;
  logic            grant_b;
  logic            wb_hs;
  logic [AW-1:0]   wb_rd;
  logic [DW-1:0]   wb_data;
  logic            wr_en;
  logic            set_en;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            hit1;
  logic            hit2;

  // Priority pointer register; reset gives A priority.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) pri_q <= PRI_A;
    else       pri_q <= pri_d;
  end

  // Arbitration and pointer update: the pointer moves only on a completed handshake.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    pri_d   = pri_q;
    case (pri_q)
      PRI_A: begin
        if (wb.a_valid)      grant_a = 1'b1;
        else if (wb.b_valid) grant_b = 1'b1;
      end
      PRI_B: begin
        if (wb.b_valid)      grant_b = 1'b1;
        else if (wb.a_valid) grant_a = 1'b1;
      end
    endcase
    if (grant_a)      pri_d = PRI_B;
    else if (grant_b) pri_d = PRI_A;
  end

  assign wb.a_ready = grant_a;
  assign wb.b_ready = grant_b;

  // A grant always coincides with valid, so a grant is a handshake.
  assign wb_hs   = grant_a | grant_b;
  assign wb_rd   = grant_a ? wb.a_rd   : wb.b_rd;
  assign wb_data = grant_a ? wb.a_data : wb.b_data;

  // Writes to x0 are accepted but never reach the RF or the scoreboard.
  assign wr_en  = wb_hs && (wb_rd != '0);
  assign set_en = issue_valid && !issue_stall && (issue_rd != '0);

  // Stalls look only at registered state, never at a same-cycle clear.
  assign issue_stall = issue_valid && (issue_rd != '0) && busy_q[issue_rd];
  assign hit1 = (rs1 != '0) && (busy_q[rs1] || (rf_we && (rf_wda == rs1)));
  assign hit2 = (rs2 != '0) && (busy_q[rs2] || (rf_we && (rf_wda == rs2)));
  assign raw_stall = hit1 | hit2;

  // Scoreboard next state: clear on writeback, set on issue, x0 forced idle.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[wb_rd]    = 1'b0;
    if (set_en) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // RF write register: address/data hold their last value when idle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rf_we  <= 1'b0;
      rf_wda <= '0;
      rf_wd  <= '0;
    end else begin
      rf_we <= wr_en;
      if (wr_en) begin
        rf_wda <= wb_rd;
        rf_wd  <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_scheduler.sv
// Bench for rf_writeback_scheduler: directed vector table, reset corner case, randomized run against a model.
module tb_rf_writeback_scheduler;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_stall;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        raw_stall;
  logic        rf_we;
  logic [4:0]  rf_wda;
  logic [31:0] rf_wd;

  rf_writeback_scheduler_if #(.DW(32), .AW(5)) wb ();

  rf_writeback_scheduler #(.DW(32), .AW(5)) dut (
    .CLK(CLK), .RESET(RESET), .wb(wb.slave),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .rs1(rs1), .rs2(rs2), .raw_stall(raw_stall),
    .rf_we(rf_we), .rf_wda(rf_wda), .rf_wd(rf_wd)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        bv;  logic [4:0] brd; logic [31:0] bd;
    logic        iv;  logic [4:0] ird;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        ear; logic ebr; logic eis; logic eraw;
    logic        ewe; logic [4:0] ewda; logic [31:0] ewd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int av, input int ard, input int ad, input int bv, input int brd, input int bd,
                     input int iv, input int ird, input int r1, input int r2,
                     input int ear, input int ebr, input int eis, input int eraw,
                     input int ewe, input int ewda, input int ewd);
    vec_t v;
    v.av = 1'(av); v.ard = 5'(ard); v.ad = 32'(ad);
    v.bv = 1'(bv); v.brd = 5'(brd); v.bd = 32'(bd);
    v.iv = 1'(iv); v.ird = 5'(ird); v.r1 = 5'(r1); v.r2 = 5'(r2);
    v.ear = 1'(ear); v.ebr = 1'(ebr); v.eis = 1'(eis); v.eraw = 1'(eraw);
    v.ewe = 1'(ewe); v.ewda = 5'(ewda); v.ewd = 32'(ewd);
    vq.push_back(v);
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2);
    wb.a_valid = av; wb.a_rd = ard; wb.a_data = ad;
    wb.b_valid = bv; wb.b_rd = brd; wb.b_data = bd;
    issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
  endtask

  // Reference model state (architectural view of the scheduler).
  bit          busy_m [32];
  bit          last_was_b;
  bit          m_we;
  logic [4:0]  m_wda;
  logic [31:0] m_wd;
  bit          a_pend;
  bit          b_pend;

  initial begin
    RESET = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("reset_rf_we", 32'(rf_we), 0);
    chk("reset_rf_wda", 32'(rf_wda), 0);
    chk("reset_rf_wd", rf_wd, 0);
    RESET = 1'b0;

    //   A: v rd data     B: v rd data     iss  rs1 rs2  ar br is raw  we wda wd
    add(0, 0, 0,         0, 0, 0,         0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0);
    add(1, 3, 'hDEADBEEF,0, 0, 0,         0, 0, 0, 0,  1, 0, 0, 0,   1, 3, 'hDEADBEEF);
    add(0, 0, 0,         0, 0, 0,         0, 0, 3, 0,  0, 0, 0, 1,   0, 0, 0);
    add(1, 1, 'h11,      1, 2, 'h22,      0, 0, 0, 0,  0, 1, 0, 0,   1, 2, 'h22);
    add(1, 1, 'h11,      1, 12, 'h2c,     0, 0, 0, 0,  1, 0, 0, 0,   1, 1, 'h11);
    add(1, 13, 'h33,     1, 12, 'h2c,     0, 0, 0, 0,  0, 1, 0, 0,   1, 12, 'h2c);
    add(1, 13, 'h33,     1, 14, 'h44,     0, 0, 0, 0,  1, 0, 0, 0,   1, 13, 'h33);
    add(0, 0, 0,         1, 14, 'h44,     0, 0, 0, 0,  0, 1, 0, 0,   1, 14, 'h44);
    add(1, 16, 'h66,     1, 17, 'h77,     0, 0, 0, 0,  1, 0, 0, 0,   1, 16, 'h66);
    add(0, 0, 0,         1, 17, 'h77,     0, 0, 0, 0,  0, 1, 0, 0,   1, 17, 'h77);
    add(0, 0, 0,         0, 0, 0,         1, 7, 0, 0,  0, 0, 0, 0,   0, 0, 0);
    add(0, 0, 0,         0, 0, 0,         0, 0, 7, 0,  0, 0, 0, 1,   0, 0, 0);
    add(0, 0, 0,         1, 7, 'hCAFE,    0, 0, 7, 0,  0, 1, 0, 1,   1, 7, 'hCAFE);
    add(0, 0, 0,         0, 0, 0,         0, 0, 7, 0,  0, 0, 0, 1,   0, 0, 0);
    add(0, 0, 0,         0, 0, 0,         0, 0, 7, 0,  0, 0, 0, 0,   0, 0, 0);
    add(0, 0, 0,         0, 0, 0,         1, 9, 0, 0,  0, 0, 0, 0,   0, 0, 0);
    add(0, 0, 0,         0, 0, 0,         1, 9, 0, 9,  0, 0, 1, 1,   0, 0, 0);
    add(1, 9, 'h99,      0, 0, 0,         1, 9, 0, 0,  1, 0, 1, 0,   1, 9, 'h99);
    add(0, 0, 0,         0, 0, 0,         1, 9, 0, 0,  0, 0, 0, 0,   0, 0, 0);
    add(1, 9, 'h999,     0, 0, 0,         0, 0, 0, 9,  1, 0, 0, 1,   1, 9, 'h999);
    add(1, 0, 'h1234,    0, 0, 0,         0, 0, 0, 9,  1, 0, 0, 1,   0, 0, 0);
    add(0, 0, 0,         0, 0, 0,         1, 0, 0, 9,  0, 0, 0, 0,   0, 0, 0);
    add(0, 0, 0,         0, 0, 0,         1, 6, 0, 0,  0, 0, 0, 0,   0, 0, 0);
    add(1, 6, 'h66,      0, 0, 0,         1, 4, 0, 0,  1, 0, 0, 0,   1, 6, 'h66);
    add(0, 0, 0,         0, 0, 0,         0, 0, 4, 0,  0, 0, 0, 1,   0, 0, 0);
    add(0, 0, 0,         0, 0, 0,         0, 0, 6, 0,  0, 0, 0, 0,   0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].av, vq[i].ard, vq[i].ad, vq[i].bv, vq[i].brd, vq[i].bd,
            vq[i].iv, vq[i].ird, vq[i].r1, vq[i].r2);
      #1;
      chk($sformatf("vec%0d_a_ready", i), 32'(wb.a_ready), 32'(vq[i].ear));
      chk($sformatf("vec%0d_b_ready", i), 32'(wb.b_ready), 32'(vq[i].ebr));
      chk($sformatf("vec%0d_issue_stall", i), 32'(issue_stall), 32'(vq[i].eis));
      chk($sformatf("vec%0d_raw_stall", i), 32'(raw_stall), 32'(vq[i].eraw));
      @(posedge CLK); #1;
      chk($sformatf("vec%0d_rf_we", i), 32'(rf_we), 32'(vq[i].ewe));
      if (vq[i].ewe) begin
        chk($sformatf("vec%0d_rf_wda", i), 32'(rf_wda), 32'(vq[i].ewda));
        chk($sformatf("vec%0d_rf_wd", i), rf_wd, vq[i].ewd);
      end
      @(negedge CLK);
    end

    // Reset mid-operation: busy[5] set, pointer at B, write pending in the output register.
    drive(1, 1, 'hAA, 0, 0, 0, 1, 5, 0, 0);
    @(posedge CLK); #1;
    chk("pre_reset_rf_we", 32'(rf_we), 1);
    @(negedge CLK);
    drive(1, 2, 'hB2, 1, 3, 'hB3, 0, 0, 5, 0);
    #1;
    chk("pre_reset_raw5", 32'(raw_stall), 1);
    chk("pre_reset_b_pri", 32'(wb.b_ready), 1);
    #1 RESET = 1'b1;
    #1;
    chk("in_reset_rf_we", 32'(rf_we), 0);
    chk("in_reset_raw5", 32'(raw_stall), 0);
    RESET = 1'b0;
    #1;
    chk("post_reset_a_ready", 32'(wb.a_ready), 1);
    chk("post_reset_b_ready", 32'(wb.b_ready), 0);
    @(posedge CLK); #1;
    chk("post_reset_rf_wda", 32'(rf_wda), 2);
    chk("post_reset_rf_wd", rf_wd, 'hB2);
    @(negedge CLK);

    // Randomized run against the model, from a fresh reset.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    RESET = 1'b1;
    #2 RESET = 1'b0;
    foreach (busy_m[k]) busy_m[k] = 1'b0;
    last_was_b = 1'b1;
    m_we = 1'b0; m_wda = '0; m_wd = '0;
    a_pend = 1'b0; b_pend = 1'b0;

    for (int c = 0; c < 1500; c++) begin
      int          g;
      logic [4:0]  grd;
      logic [31:0] gdat;
      bit          e_is, e_raw, set_ok;
      if (!a_pend) begin
        wb.a_valid = ($urandom_range(0, 2) != 0);
        wb.a_rd    = 5'($urandom_range(0, 7));
        wb.a_data  = $urandom;
      end
      if (!b_pend) begin
        wb.b_valid = ($urandom_range(0, 2) != 0);
        wb.b_rd    = 5'($urandom_range(0, 7));
        wb.b_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_rd    = 5'($urandom_range(0, 7));
      if (issue_rd != 0 && ((wb.a_valid && wb.a_rd == issue_rd) || (wb.b_valid && wb.b_rd == issue_rd)))
        issue_valid = 1'b0;
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));

      // Grant: the source not granted last wins a tie.
      if (wb.a_valid && wb.b_valid) g = last_was_b ? 1 : 2;
      else if (wb.a_valid)          g = 1;
      else if (wb.b_valid)          g = 2;
      else                          g = 0;
      grd  = (g == 1) ? wb.a_rd : wb.b_rd;
      gdat = (g == 1) ? wb.a_data : wb.b_data;
      e_is  = issue_valid && issue_rd != 0 && busy_m[issue_rd];
      e_raw = (rs1 != 0 && (busy_m[rs1] || (m_we && m_wda == rs1))) ||
              (rs2 != 0 && (busy_m[rs2] || (m_we && m_wda == rs2)));
      set_ok = issue_valid && !e_is && issue_rd != 0;

      #1;
      chk("rnd_a_ready", 32'(wb.a_ready), 32'(g == 1));
      chk("rnd_b_ready", 32'(wb.b_ready), 32'(g == 2));
      chk("rnd_issue_stall", 32'(issue_stall), 32'(e_is));
      chk("rnd_raw_stall", 32'(raw_stall), 32'(e_raw));

      if (g != 0) begin
        last_was_b = (g == 2);
        if (grd != 0) busy_m[grd] = 1'b0;
      end
      if (set_ok) busy_m[issue_rd] = 1'b1;
      m_we = (g != 0) && (grd != 0);
      if (m_we) begin
        m_wda = grd;
        m_wd  = gdat;
      end
      a_pend = wb.a_valid && (g != 1);
      b_pend = wb.b_valid && (g != 2);

      @(posedge CLK); #1;
      chk("rnd_rf_we", 32'(rf_we), 32'(m_we));
      if (m_we) begin
        chk("rnd_rf_wda", 32'(rf_wda), 32'(m_wda));
        chk("rnd_rf_wd", rf_wd, m_wd);
      end
      @(negedge CLK);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
